// File: rtl/key_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// key_sequencer_pkg
//   Shared types and constants for the PS/2 key sequencing path.
//   - state_e   : sequencer FSM states (IDLE, MAKE, HOLD, BREAK, GAP)
//   - KEY_W     : width of a key code from the typing source
//   - BREAK_BIT : bit of savedByte that flags a break byte
//   - BYTE_W    : width of a byte handed to the PS/2 controller
//   - build_byte: packs break flag and key code into a controller byte
// -----------------------------------------------------------------------------
package key_sequencer_pkg;

    localparam int KEY_W     = 7;
    localparam int BREAK_BIT = 7;
    localparam int BYTE_W    = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MAKE  = 3'd1,
        HOLD  = 3'd2,
        BREAK = 3'd3,
        GAP   = 3'd4
    } state_e;

    // The controller prefixes F0 when the top bit is set, so a break byte
    // is simply the key code with BREAK_BIT raised.
    function automatic logic [BYTE_W-1:0] build_byte(input logic brk,
                                                     input logic [KEY_W-1:0] key);
        logic [BYTE_W-1:0] b;
        b            = {1'b0, key};
        b[BREAK_BIT] = brk;
        return b;
    endfunction

endpackage

// File: rtl/key_sequencer_if.sv
// -----------------------------------------------------------------------------
// key_sequencer_if
//   Byte handshake between key_sequencer and ps2_controller.
//   - keyReady  : byte request, held until txDone
//   - savedByte : [7]=break flag, [6:0]=key code, stable while keyReady
//   - txDone    : one-cycle pulse, current byte fully sent
//   modport master : sequencer side (drives keyReady/savedByte)
//   modport slave  : controller side (drives txDone)
// -----------------------------------------------------------------------------
interface key_sequencer_if;
    import key_sequencer_pkg::*;

    logic              keyReady;
    logic [BYTE_W-1:0] savedByte;
    logic              txDone;

    modport master (
        output keyReady,
        output savedByte,
        input  txDone
    );

    modport slave (
        input  keyReady,
        input  savedByte,
        output txDone
    );

endinterface

// File: rtl/key_sequencer_fifo.sv
// -----------------------------------------------------------------------------
// key_fifo
//   Synchronous first-word-fall-through FIFO for queued key codes.
//   Ports:
//   - clk, RST : clock, synchronous active-high reset (empties the FIFO)
//   - push     : write wdata; ignored while full (even with a same-cycle pop)
//   - pop      : drop head entry; ignored while empty
//   - wdata    : entry to write
//   - rdata    : current head entry (valid whenever empty is low)
//   - full     : registered, FIFO holds DEPTH entries
//   - empty    : registered, FIFO holds no entries
// -----------------------------------------------------------------------------
module key_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify requests and compute next pointers, occupancy and flags.
    always_comb begin
        push_ok_s = push && !full_q;
        pop_ok_s  = pop && !empty_q;

        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Flags are registered from the next count so they line up with count_q.
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == {CNT_W{1'b0}});
    end

    // Pointer, occupancy and flag registers.
    always_ff @(posedge clk) begin
        if (RST) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array; contents need no reset since empty gates every read.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/key_sequencer.sv
// -----------------------------------------------------------------------------
// key_sequencer
//   Upstream stage of the PS/2 transmit path. Queues key codes and turns each
//   into make byte -> hold delay -> break byte -> inter-key gap, handing every
//   byte to the PS/2 controller over the keyReady/savedByte/txDone handshake.
//   Ports:
//   - clk       : system clock (30 MHz)
//   - RST       : synchronous active-high reset, also aborts an in-flight key
//   - keyIn     : 7-bit key code from the source
//   - keyValid  : one-cycle push strobe for keyIn (accepted in every state)
//   - ps2       : byte handshake towards ps2_controller (master side)
//   - fifoFull  : registered, key FIFO holds DEPTH entries
//   - overflow  : registered one-cycle pulse, a push was dropped while full
// -----------------------------------------------------------------------------
module key_sequencer
    import key_sequencer_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int HOLD_CYCLES = 300000,
    parameter int GAP_CYCLES  = 150000
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [KEY_W-1:0] keyIn,
    input  logic             keyValid,
    key_sequencer_if.master  ps2,
    output logic             fifoFull,
    output logic             overflow
);

    localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [KEY_W-1:0]  cur_key_q, cur_key_d;
    logic              key_ready_q, key_ready_d;
    logic [BYTE_W-1:0] saved_byte_q, saved_byte_d;
    logic              overflow_q, overflow_d;

    logic              pop_s;
    logic [KEY_W-1:0]  fifo_rdata_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;

    // The FIFO drops a push on its own when full, so keyValid feeds it directly.
    key_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (KEY_W)
    ) u_fifo (
        .clk   (clk),
        .RST   (RST),
        .push  (keyValid),
        .pop   (pop_s),
        .wdata (keyIn),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Next-state, delay counter and output-register logic of the key FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cur_key_d    = cur_key_q;
        key_ready_d  = key_ready_q;
        saved_byte_d = saved_byte_q;
        pop_s        = 1'b0;

        case (state_q)
            IDLE: begin
                // Head of the FIFO is visible before the pop (fall-through).
                if (!fifo_empty_s) begin
                    pop_s        = 1'b1;
                    cur_key_d    = fifo_rdata_s;
                    saved_byte_d = build_byte(1'b0, fifo_rdata_s);
                    key_ready_d  = 1'b1;
                    state_d      = MAKE;
                end else begin
                    state_d = IDLE;
                end
            end

            MAKE: begin
                // txDone may arrive in the first cycle keyReady is high.
                if (ps2.txDone) begin
                    key_ready_d = 1'b0;
                    cnt_d       = {CNT_W{1'b0}};
                    state_d     = HOLD;
                end else begin
                    state_d = MAKE;
                end
            end

            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    saved_byte_d = build_byte(1'b1, cur_key_q);
                    key_ready_d  = 1'b1;
                    state_d      = BREAK;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = HOLD;
                end
            end

            BREAK: begin
                if (ps2.txDone) begin
                    key_ready_d = 1'b0;
                    cnt_d       = {CNT_W{1'b0}};
                    state_d     = GAP;
                end else begin
                    state_d = BREAK;
                end
            end

            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = GAP;
                end
            end

            default: begin
                // Unreachable encoding: withdraw any request and restart.
                key_ready_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // A push strobe that meets a full FIFO is reported one cycle later.
    always_comb begin
        if (keyValid && fifo_full_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = 1'b0;
        end
    end

    // FSM state, delay counter and registered outputs.
    always_ff @(posedge clk) begin
        if (RST) begin
            state_q      <= IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            cur_key_q    <= {KEY_W{1'b0}};
            key_ready_q  <= 1'b0;
            saved_byte_q <= {BYTE_W{1'b0}};
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cur_key_q    <= cur_key_d;
            key_ready_q  <= key_ready_d;
            saved_byte_q <= saved_byte_d;
            overflow_q   <= overflow_d;
        end
    end

    assign ps2.keyReady  = key_ready_q;
    assign ps2.savedByte = saved_byte_q;
    assign fifoFull      = fifo_full_s;
    assign overflow      = overflow_q;

endmodule
